scan_display_driver: RTL

Time-multiplexed display scanner for the digital clock's common-anode seven-segment bank. It cycles through `DIGITS` digit positions, driving one at a time with a fixed dwell time per slot. Each slot opens with a blanking window to suppress ghosting and then applies PWM brightness control. Digits can be skipped via an enable mask, and each digit's value is latched at slot start so mid-slot updates cannot tear. It sits between the time/format logic and the FPGA pins.

---
 rtl/display_pkg.sv | 26 ++
 rtl/next_enabled.sv | 28 ++
 rtl/scan_display_driver.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and polarity helpers for the seven-segment scan driver.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BLANK,
        ST_ACTIVE
    } scan_state_t;

    localparam int POL_ACT_HIGH = 0;
    localparam int POL_ACT_LOW  = 1;

    // Level of an inactive line: high when the line is active-low.
    function automatic logic off_level(input int act_low);
        return act_low != POL_ACT_HIGH;
    endfunction

    function automatic logic off_seg(input int seg_act_low);
        return off_level(seg_act_low);
    endfunction

    function automatic logic off_sel(input int sel_act_low);
        return off_level(sel_act_low);
    endfunction

endpackage

// File: rtl/next_enabled.sv
// Cyclic priority search: lowest enabled index above cur, else lowest enabled overall.
module next_enabled #(
    parameter int DIGITS = 4,
    localparam int IW = $clog2(DIGITS)
) (
    input  logic [IW-1:0]     cur,
    input  logic [DIGITS-1:0] mask,
    output logic [IW-1:0]     nxt,
    output logic              wrap,
    output logic              any
);

    always_comb begin
        nxt  = '0;
        wrap = 1'b1;
        any  = |mask;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) nxt = IW'(i);
        end
        for (int i = DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (i > int'(cur))) begin
                nxt  = IW'(i);
                wrap = 1'b0;
            end
        end
    end

endmodule

// File: rtl/scan_display_driver.sv
// Time-multiplexed seven-segment scanner with per-slot blanking and PWM dimming.
//  state     | meaning
//  ST_IDLE   | no digit enabled; outputs off, cur_digit held
//  ST_BLANK  | start of slot; all outputs off (anti-ghosting)
//  ST_ACTIVE | selected digit lit according to PWM duty
module scan_display_driver
    import display_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int WIDTH       = 8,
    parameter int DWELL       = 50000,
    parameter int BLANK       = 500,
    parameter int BRIGHT_W    = 4,
    parameter int SEL_ACT_LOW = POL_ACT_LOW,
    parameter int SEG_ACT_LOW = POL_ACT_LOW
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [DIGITS*WIDTH-1:0]    in_value,
    input  logic [DIGITS-1:0]          digit_en,
    input  logic [BRIGHT_W-1:0]        brightness,
    output logic [WIDTH-1:0]           seg_out,
    output logic [DIGITS-1:0]          sel_out,
    output logic [$clog2(DIGITS)-1:0]  cur_digit,
    output logic                       frame_start
);

    localparam int IW = $clog2(DIGITS);
    localparam int CW = $clog2(DWELL + 1);
    localparam logic [CW-1:0] LAST_CNT  = CW'(DWELL - 1);
    localparam logic [CW-1:0] BLANK_CNT = CW'(BLANK);
    localparam scan_state_t ST_FIRST = (BLANK == 0) ? ST_ACTIVE : ST_BLANK;
    localparam logic [WIDTH-1:0]  OFF_SEG = {WIDTH{off_seg(SEG_ACT_LOW)}};
    localparam logic [DIGITS-1:0] OFF_SEL = {DIGITS{off_sel(SEL_ACT_LOW)}};

    scan_state_t          state;
    logic [CW-1:0]        slot_cnt;
    logic [BRIGHT_W-1:0]  pwm_cnt;
    logic [IW-1:0]        cur_idx;
    logic [WIDTH-1:0]     seg_lat;
    logic [BRIGHT_W-1:0]  br_lat;
    logic                 fresh;
    logic                 frame_flag;

    logic [IW-1:0]        search_from;
    logic [IW-1:0]        nidx;
    logic                 nwrap;
    logic                 nany;

    logic                 start;
    logic [IW-1:0]        slot_idx;
    logic [WIDTH-1:0]     seg_eff;
    logic [BRIGHT_W-1:0]  br_eff;
    logic [DIGITS-1:0]    sel_hot;
    logic                 lit;

    // After reset or from IDLE the search starts past the top so it yields the lowest enabled digit.
    assign search_from = (fresh || state == ST_IDLE) ? IW'(DIGITS - 1) : cur_idx;

    next_enabled #(.DIGITS(DIGITS)) u_next (
        .cur  (search_from),
        .mask (digit_en),
        .nxt  (nidx),
        .wrap (nwrap),
        .any  (nany)
    );

    // On a slot's first cycle the live inputs are used directly, so the slot shows them without delay.
    always_comb begin
        start    = (state != ST_IDLE) && (slot_cnt == '0) && (!fresh || nany);
        slot_idx = fresh ? nidx : cur_idx;
        seg_eff  = start ? in_value[int'(slot_idx)*WIDTH +: WIDTH] : seg_lat;
        br_eff   = start ? brightness : br_lat;
        sel_hot  = '0;
        sel_hot[slot_idx] = 1'b1;
        lit = (state == ST_ACTIVE) && ((pwm_cnt < br_eff) || (&br_eff));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_FIRST;
            slot_cnt    <= '0;
            pwm_cnt     <= '0;
            cur_idx     <= '0;
            seg_lat     <= '0;
            br_lat      <= '0;
            fresh       <= 1'b1;
            frame_flag  <= 1'b1;
            seg_out     <= OFF_SEG;
            sel_out     <= OFF_SEL;
            cur_digit   <= '0;
            frame_start <= 1'b0;
        end else begin
            seg_out     <= lit ? (seg_eff ^ OFF_SEG) : OFF_SEG;
            sel_out     <= lit ? (sel_hot ^ OFF_SEL) : OFF_SEL;
            cur_digit   <= slot_idx;
            frame_start <= start && frame_flag;
            fresh       <= 1'b0;

            if (start) begin
                seg_lat <= seg_eff;
                br_lat  <= br_eff;
                cur_idx <= slot_idx;
            end

            case (state)
                ST_IDLE: begin
                    if (nany) begin
                        state      <= ST_FIRST;
                        slot_cnt   <= '0;
                        pwm_cnt    <= '0;
                        cur_idx    <= nidx;
                        frame_flag <= 1'b1;
                    end
                end
                default: begin
                    if (fresh && !nany) begin
                        state <= ST_IDLE;
                    end else if (slot_cnt == LAST_CNT) begin
                        slot_cnt <= '0;
                        pwm_cnt  <= '0;
                        if (nany) begin
                            state      <= ST_FIRST;
                            cur_idx    <= nidx;
                            frame_flag <= nwrap;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end else begin
                        slot_cnt <= slot_cnt + 1'b1;
                        if (state == ST_ACTIVE) begin
                            pwm_cnt <= pwm_cnt + 1'b1;
                        end else if (slot_cnt + 1'b1 == BLANK_CNT) begin
                            state <= ST_ACTIVE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
